// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard-detection inputs from the ID and EX stages,
// the data-memory handshake, and the per-register pipeline controls.
//   master : the hazard controller (drives enables, flushes, mem_req, status)
//   slave  : the pipeline datapath / memory side (drives operand info, mem_ack)
// Parameter CNT_W sets the width of the stall performance counter.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_op;
  logic             mem_ack;
  logic             mem_req;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;
  logic             fault;
  logic [CNT_W-1:0] stall_count;

  modport master (
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_memread, ex_rd,
           ex_branch_taken, mem_op, mem_ack,
    output mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_bubble, fault, stall_count
  );

  modport slave (
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_memread, ex_rd,
           ex_branch_taken, mem_op, mem_ack,
    input  mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_bubble, fault, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencing controller. Produces capture enables and
// flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB; handles load-use hazards,
// taken-branch redirects and multi-cycle data-memory accesses; raises a sticky
// fault when a memory access stalls longer than TIMEOUT cycles; counts stall
// cycles in a saturating counter.
// Ports:
//   clk   : controller clock (state updates on rising edge; pipeline registers
//           capture on the falling edge, so outputs settle in the first half)
//   rst_n : asynchronous active-low reset; forces all controls low while low
//   hz    : pipeline_hazard_ctrl_if master modport (see interface file)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_RUN    | normal flow; branch / load-use / new memory stall detected here
// S_MEM_WAIT| data-memory access outstanding; pipeline frozen until mem_ack
// S_FAULT  | memory timeout; pipeline frozen until reset
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.master hz
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FAULT    = 2'd2
  } state_t;

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic               mem_stall;
  logic               load_use;
  logic [WAIT_W-1:0]  stall_k;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_bubble, mem_req;

  assign mem_stall = ((state_q == S_RUN) && hz.mem_op && !hz.mem_ack) ||
                     ((state_q == S_MEM_WAIT) && !hz.mem_ack);

  assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                    ((hz.id_rs_used && (hz.id_rs == hz.ex_rd)) ||
                     (hz.id_rt_used && (hz.id_rt == hz.ex_rd)));

  // Stall cycle number of the current cycle: a stall raised from RUN is cycle 1.
  assign stall_k = (state_q == S_RUN) ? WAIT_W'(1) : wait_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (mem_stall) begin
          if (stall_k == TIMEOUT_V) begin
            state_d    = S_FAULT;
            wait_cnt_d = '0;
          end else begin
            state_d    = S_MEM_WAIT;
            wait_cnt_d = stall_k + WAIT_W'(1);
          end
        end else if (state_q == S_MEM_WAIT) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    mem_req      = 1'b0;
    // Reset gates the controls combinationally so a reset in MEM_WAIT drops
    // mem_req immediately, not at the next edge.
    if (rst_n && (state_q != S_FAULT)) begin
      if (mem_stall) begin
        memwb_en     = 1'b1;
        memwb_bubble = 1'b1;
        mem_req      = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        // Keep the request up through the release cycle of a wait.
        mem_req  = hz.mem_op || (state_q == S_MEM_WAIT);
        if (hz.ex_branch_taken) begin
          // ID instruction is discarded, so any load-use on it is moot.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((state_q != S_FAULT) && !pc_en && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.idex_en      = idex_en;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_en     = memwb_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_flush   = idex_flush;
  assign hz.memwb_bubble = memwb_bubble;
  assign hz.mem_req      = mem_req;
  assign hz.fault        = (state_q == S_FAULT);
  assign hz.stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl with TIMEOUT=4, CNT_W=4.
// Output vectors are packed as
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble, mem_req}.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;

  localparam logic [8:0] O_ZERO    = 9'b000000000;
  localparam logic [8:0] O_NORM    = 9'b111110000;
  localparam logic [8:0] O_LU      = 9'b001110100;
  localparam logic [8:0] O_BR      = 9'b111111100;
  localparam logic [8:0] O_MST     = 9'b000010011;
  localparam logic [8:0] O_MREQ    = 9'b111110001;
  localparam logic [8:0] O_LU_MREQ = 9'b001110101;

  logic clk = 1'b0;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       mem_op;
    logic       mem_ack;
    logic [8:0] exp_out;
    logic       inc;
  } vec_t;

  vec_t vecs[11];
  int total = 0;
  int bad   = 0;
  int exp_cnt;

  function automatic vec_t mk(string nm, logic [4:0] rs, logic [4:0] rt, logic rsu,
                              logic rtu, logic mr, logic [4:0] rd, logic br,
                              logic mo, logic ma, logic [8:0] eo, logic inc);
    vec_t v;
    v.name = nm; v.rs = rs; v.rt = rt; v.rs_used = rsu; v.rt_used = rtu;
    v.memread = mr; v.rd = rd; v.br = br; v.mem_op = mo; v.mem_ack = ma;
    v.exp_out = eo; v.inc = inc;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.memwb_bubble, hz.mem_req};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic mr, input logic [4:0] rd,
                        input logic br, input logic mo, input logic ma);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_rs_used = rsu; hz.id_rt_used = rtu;
    hz.ex_memread = mr; hz.ex_rd = rd; hz.ex_branch_taken = br;
    hz.mem_op = mo; hz.mem_ack = ma;
  endtask

  // Ends at posedge+1 with the controller in RUN and a zeroed counter.
  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = 0;
  endtask

  initial begin
    vecs[0]  = mk("normal",        0,  0, 0, 0, 0,  0, 0, 0, 0, O_NORM,    0);
    vecs[1]  = mk("lu_rs",         7,  3, 1, 0, 1,  7, 0, 0, 0, O_LU,      1);
    vecs[2]  = mk("lu_rd0",        0,  0, 1, 1, 1,  0, 0, 0, 0, O_NORM,    0);
    vecs[3]  = mk("lu_rt",         4, 12, 1, 1, 1, 12, 0, 0, 0, O_LU,      1);
    vecs[4]  = mk("rs_unused",     9,  2, 0, 1, 1,  9, 0, 0, 0, O_NORM,    0);
    vecs[5]  = mk("no_load",       5,  5, 1, 1, 0,  5, 0, 0, 0, O_NORM,    0);
    vecs[6]  = mk("branch",        1,  2, 1, 1, 0,  3, 1, 0, 0, O_BR,      0);
    vecs[7]  = mk("branch_lu",     7,  0, 1, 0, 1,  7, 1, 0, 0, O_BR,      0);
    vecs[8]  = mk("mem_ack_now",   0,  0, 0, 0, 0,  0, 0, 1, 1, O_MREQ,    0);
    vecs[9]  = mk("mem_ack_lu",   31,  0, 1, 0, 1, 31, 0, 1, 1, O_LU_MREQ, 1);
    vecs[10] = mk("no_match",      6,  8, 1, 1, 1, 10, 0, 0, 0, O_NORM,    0);

    // Reset state: everything low while rst_n is held.
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_outs",  16'(outs()), 16'(O_ZERO));
    chk("reset_cnt",   16'(hz.stall_count), 16'd0);
    chk("reset_fault", 16'(hz.fault), 16'd0);

    do_reset();
    foreach (vecs[i]) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].rs_used, vecs[i].rt_used, vecs[i].memread,
             vecs[i].rd, vecs[i].br, vecs[i].mem_op, vecs[i].mem_ack);
      @(negedge clk);
      chk({vecs[i].name, "_outs"}, 16'(outs()), 16'(vecs[i].exp_out));
      @(posedge clk);
      #1;
      if (vecs[i].inc && exp_cnt < 15) exp_cnt++;
      chk({vecs[i].name, "_cnt"}, 16'(hz.stall_count), 16'(exp_cnt));
    end

    // Memory wait: three stall cycles then release.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("mw_stall%0d", k), 16'(outs()), 16'(O_MST));
      @(posedge clk);
      #1;
    end
    hz.mem_ack = 1'b1;
    @(negedge clk);
    chk("mw_release", 16'(outs()), 16'(O_MREQ));
    @(posedge clk);
    #1;
    chk("mw_cnt", 16'(hz.stall_count), 16'd3);
    chk("mw_fault", 16'(hz.fault), 16'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mw_back_run", 16'(outs()), 16'(O_NORM));

    // Timeout: four stall cycles, fault from cycle 5, sticky.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("to_stall%0d", k), 16'(outs()), 16'(O_MST));
      chk($sformatf("to_nofault%0d", k), 16'(hz.fault), 16'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("to_fault_outs", 16'(outs()), 16'(O_ZERO));
    chk("to_fault", 16'(hz.fault), 16'd1);
    chk("to_cnt", 16'(hz.stall_count), 16'd4);
    hz.mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("to_sticky_outs", 16'(outs()), 16'(O_ZERO));
    chk("to_sticky_fault", 16'(hz.fault), 16'd1);
    chk("to_sticky_cnt", 16'(hz.stall_count), 16'd4);

    // Asynchronous reset during MEM_WAIT stall cycle 2.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ar_wait_outs", 16'(outs()), 16'(O_MST));
    chk("ar_wait_cnt", 16'(hz.stall_count), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_outs", 16'(outs()), 16'(O_ZERO));
    chk("ar_cnt", 16'(hz.stall_count), 16'd0);
    hz.mem_op = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_post_outs", 16'(outs()), 16'(O_NORM));
    @(posedge clk);
    #1;
    chk("ar_post_cnt", 16'(hz.stall_count), 16'd0);

    // Saturation: 20 load-use cycles on a 4-bit counter.
    do_reset();
    set_in(7, 0, 1, 0, 1, 7, 0, 0, 0);
    @(negedge clk);
    chk("sat_outs", 16'(outs()), 16'(O_LU));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) chk("sat_cnt15", 16'(hz.stall_count), 16'd15);
    end
    chk("sat_cnt20", 16'(hz.stall_count), 16'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
